// File: rtl/onehot_demux_buf.sv
// onehot_demux_buf: steers one payload per cycle into one of N_OUTS channels,
// selected by a one-hot destination vector. Each channel has its own 2-entry FIFO
// and valid/ready handshake, so a stalled consumer only blocks its own channel.
//
// Ports:
//   clk        rising-edge clock
//   rst_aL     asynchronous active-low reset
//   in_valid   upstream payload valid
//   in_ready   upstream may transfer (sel one-hot and target channel can accept)
//   in_data    payload
//   in_sel     one-hot destination channel
//   out_valid  per-channel head valid
//   out_ready  per-channel consumer ready
//   out_data   per-channel head payload (index = channel)
//   occ        per-channel occupancy 0..2
//   sel_err    sticky flag: valid seen with a non-one-hot in_sel
module onehot_demux_buf #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned N_OUTS = 4
) (
    input  logic                           clk,
    input  logic                           rst_aL,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    input  logic [N_OUTS-1:0]              in_sel,
    output logic [N_OUTS-1:0]              out_valid,
    input  logic [N_OUTS-1:0]              out_ready,
    output logic [N_OUTS-1:0][WIDTH-1:0]   out_data,
    output logic [N_OUTS-1:0][1:0]         occ,
    output logic                           sel_err
);

    localparam logic [N_OUTS-1:0] SelOne = {{(N_OUTS-1){1'b0}}, 1'b1};

    logic [N_OUTS-1:0][1:0][WIDTH-1:0] mem_q, mem_d;
    logic [N_OUTS-1:0]                 rd_ptr_q, rd_ptr_d;
    logic [N_OUTS-1:0]                 wr_ptr_q, wr_ptr_d;
    logic [N_OUTS-1:0][1:0]            occ_q, occ_d;
    logic                              sel_err_q, sel_err_d;

    logic                              sel_ok;
    logic [N_OUTS-1:0]                 can_accept;
    logic [N_OUTS-1:0]                 push;
    logic [N_OUTS-1:0]                 pop;

    // Outputs come straight from storage; no bypass from in_data.
    always_comb begin
        for (int k = 0; k < N_OUTS; k++) begin
            out_valid[k] = (occ_q[k] != 2'd0);
            out_data[k]  = mem_q[k][rd_ptr_q[k]];
        end
        occ     = occ_q;
        sel_err = sel_err_q;
    end

    always_comb begin
        // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
        sel_ok = (in_sel != '0) && ((in_sel & (in_sel - SelOne)) == '0);
        for (int k = 0; k < N_OUTS; k++) begin
            // A full channel still accepts if its head leaves this same cycle.
            can_accept[k] = (occ_q[k] != 2'd2) || out_ready[k];
        end
        in_ready = sel_ok && ((in_sel & can_accept) != '0);
        push     = (in_valid && in_ready) ? in_sel : '0;
        pop      = out_valid & out_ready;
    end

    always_comb begin
        mem_d     = mem_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        occ_d     = occ_q;
        sel_err_d = sel_err_q | (in_valid & ~sel_ok);
        for (int k = 0; k < N_OUTS; k++) begin
            if (push[k]) begin
                mem_d[k][wr_ptr_q[k]] = in_data;
                wr_ptr_d[k]           = ~wr_ptr_q[k];
            end
            if (pop[k]) begin
                rd_ptr_d[k] = ~rd_ptr_q[k];
            end
            case ({push[k], pop[k]})
                2'b10:   occ_d[k] = occ_q[k] + 2'd1;
                2'b01:   occ_d[k] = occ_q[k] - 2'd1;
                default: occ_d[k] = occ_q[k];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            occ_q     <= '0;
            sel_err_q <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            occ_q     <= occ_d;
            sel_err_q <= sel_err_d;
        end
    end

    // Payload storage needs no reset: it is only observed while out_valid is high.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    for (genvar g = 0; g < N_OUTS; g++) begin : g_chk
        a_occ_max : assert property (@(posedge clk) disable iff (!rst_aL)
            occ_q[g] <= 2'd2);
        a_valid_occ : assert property (@(posedge clk) disable iff (!rst_aL)
            out_valid[g] == (occ_q[g] != 2'd0));
    end

    a_one_push : assert property (@(posedge clk) disable iff (!rst_aL) $onehot0(push));

endmodule

// File: tb/tb_onehot_demux_buf.sv
module tb_onehot_demux_buf;

    localparam int WIDTH  = 32;
    localparam int N_OUTS = 4;

    logic                         clk;
    logic                         rst_aL;
    logic                         in_valid;
    logic                         in_ready;
    logic [WIDTH-1:0]             in_data;
    logic [N_OUTS-1:0]            in_sel;
    logic [N_OUTS-1:0]            out_valid;
    logic [N_OUTS-1:0]            out_ready;
    logic [N_OUTS-1:0][WIDTH-1:0] out_data;
    logic [N_OUTS-1:0][1:0]       occ;
    logic                         sel_err;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: one queue per channel plus the sticky error flag.
    logic [WIDTH-1:0] mq [N_OUTS][$];
    bit               sel_err_m;

    onehot_demux_buf #(.WIDTH(WIDTH), .N_OUTS(N_OUTS)) dut (
        .clk       (clk),
        .rst_aL    (rst_aL),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occ       (occ),
        .sel_err   (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit exp_ready();
        int ch;
        ch = -1;
        if ($countones(in_sel) != 1) return 1'b0;
        for (int k = 0; k < N_OUTS; k++) if (in_sel[k]) ch = k;
        return (mq[ch].size() < 2) || out_ready[ch];
    endfunction

    function automatic logic [N_OUTS-1:0] exp_valid();
        logic [N_OUTS-1:0] v;
        for (int k = 0; k < N_OUTS; k++) v[k] = (mq[k].size() != 0);
        return v;
    endfunction

    function automatic logic [N_OUTS-1:0][1:0] exp_occ();
        logic [N_OUTS-1:0][1:0] o;
        for (int k = 0; k < N_OUTS; k++) o[k] = 2'(mq[k].size());
        return o;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < N_OUTS; k++) mq[k].delete();
        sel_err_m = 1'b0;
    endtask

    // Advance one clock edge, updating the model from the inputs held across it.
    task automatic tick();
        bit               acc;
        bit [N_OUTS-1:0]  popm;
        logic [WIDTH-1:0] d;
        logic [N_OUTS-1:0] s;
        acc = in_valid && exp_ready();
        d   = in_data;
        s   = in_sel;
        for (int k = 0; k < N_OUTS; k++) popm[k] = (mq[k].size() != 0) && out_ready[k];
        if (in_valid && $countones(in_sel) != 1) sel_err_m = 1'b1;
        @(posedge clk);
        for (int k = 0; k < N_OUTS; k++) begin
            if (popm[k]) void'(mq[k].pop_front());
            if (acc && s[k]) mq[k].push_back(d);
        end
        #1;
    endtask

    task automatic test_reset();
        rst_aL    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = 4'b0001;
        out_ready = '0;
        model_clear();
        #3;
        @(negedge clk);
        rst_aL = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (out_valid !== 4'b0000) begin
                miscompares++;
                $display("FAIL reset_valid: got %b expected 0000", out_valid);
            end
            vectors++;
            if (occ !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_occ: got %h expected 00", occ);
            end
            vectors++;
            if (sel_err !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_sel_err: got %b expected 0", sel_err);
            end
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_in_ready: got %b expected 1", in_ready);
            end
            tick();
        end
    endtask

    task automatic test_fill_order();
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_sel    = 4'b0100;
        in_data   = 32'hA1;
        #1;
        tick();
        in_valid = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 4'b0100 || out_data[2] !== 32'hA1 || occ[2] !== 2'd1) begin
            miscompares++;
            $display("FAIL fill_first: got v=%b d=%h occ=%0d expected v=0100 d=a1 occ=1",
                     out_valid, out_data[2], occ[2]);
        end
        in_valid = 1'b1;
        in_data  = 32'hA2;
        #1;
        tick();
        in_data = 32'hA3;
        #1;
        vectors++;
        if (in_ready !== 1'b0 || occ[2] !== 2'd2) begin
            miscompares++;
            $display("FAIL fill_full: got rdy=%b occ=%0d expected rdy=0 occ=2", in_ready, occ[2]);
        end
        out_ready = 4'b0100;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_data[2] !== 32'hA1) begin
            miscompares++;
            $display("FAIL fill_pop_push: got rdy=%b d=%h expected rdy=1 d=a1",
                     in_ready, out_data[2]);
        end
        tick();
        in_valid = 1'b0;
        #1;
        vectors++;
        if (out_data[2] !== 32'hA2 || occ[2] !== 2'd2) begin
            miscompares++;
            $display("FAIL fill_second: got d=%h occ=%0d expected d=a2 occ=2",
                     out_data[2], occ[2]);
        end
        tick();
        vectors++;
        if (out_data[2] !== 32'hA3 || occ[2] !== 2'd1) begin
            miscompares++;
            $display("FAIL fill_third: got d=%h occ=%0d expected d=a3 occ=1",
                     out_data[2], occ[2]);
        end
        tick();
        vectors++;
        if (out_valid !== exp_valid() || occ !== exp_occ()) begin
            miscompares++;
            $display("FAIL fill_drained: got v=%b occ=%h expected v=%b occ=%h",
                     out_valid, occ, exp_valid(), exp_occ());
        end
        out_ready = 4'b0000;
    endtask

    task automatic test_no_hol();
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_sel    = 4'b0001;
        for (int i = 0; i < 2; i++) begin
            in_data = 32'h100 + i;
            #1;
            tick();
        end
        in_sel  = 4'b0010;
        in_data = 32'h55;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || occ[0] !== 2'd2) begin
            miscompares++;
            $display("FAIL hol_accept: got rdy=%b occ0=%0d expected rdy=1 occ0=2",
                     in_ready, occ[0]);
        end
        tick();
        in_valid = 1'b0;
        #1;
        vectors++;
        if (out_valid[1] !== 1'b1 || out_data[1] !== 32'h55) begin
            miscompares++;
            $display("FAIL hol_ch1: got v=%b d=%h expected v=1 d=55", out_valid[1], out_data[1]);
        end
        out_ready = 4'b1111;
        repeat (3) tick();
        vectors++;
        if (out_valid !== 4'b0000 || out_valid !== exp_valid()) begin
            miscompares++;
            $display("FAIL hol_drain: got %b expected 0000", out_valid);
        end
        out_ready = 4'b0000;
    endtask

    task automatic test_stream();
        out_ready = 4'b1000;
        in_valid  = 1'b1;
        in_sel    = 4'b1000;
        for (int i = 0; i < 8; i++) begin
            in_data = 32'h30 + i;
            #1;
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL stream_ready beat %0d: got %b expected 1", i, in_ready);
            end
            if (i > 0) begin
                vectors++;
                if (occ[3] !== 2'd1 || out_data[3] !== 32'(32'h30 + i - 1)) begin
                    miscompares++;
                    $display("FAIL stream_beat %0d: got occ=%0d d=%h expected occ=1 d=%h",
                             i, occ[3], out_data[3], 32'h30 + i - 1);
                end
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        vectors++;
        if (out_data[3] !== 32'h37 || occ[3] !== 2'd1) begin
            miscompares++;
            $display("FAIL stream_last: got d=%h occ=%0d expected d=37 occ=1",
                     out_data[3], occ[3]);
        end
        tick();
        vectors++;
        if (out_valid[3] !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_empty: got %b expected 0", out_valid[3]);
        end
        out_ready = 4'b0000;
    endtask

    task automatic test_sel_err();
        logic [N_OUTS-1:0][1:0] occ_before;
        in_valid = 1'b1;
        in_data  = 32'hDEAD;
        in_sel   = 4'b0001;
        #1;
        tick();
        occ_before = exp_occ();
        in_sel = 4'b0000;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL selerr_zero_ready: got %b expected 0", in_ready);
        end
        tick();
        vectors++;
        if (sel_err !== 1'b1 || occ !== occ_before) begin
            miscompares++;
            $display("FAIL selerr_zero: got err=%b occ=%h expected err=1 occ=%h",
                     sel_err, occ, occ_before);
        end
        in_sel = 4'b0110;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL selerr_multi_ready: got %b expected 0", in_ready);
        end
        tick();
        in_valid = 1'b0;
        tick();
        vectors++;
        if (sel_err !== 1'b1 || occ !== occ_before) begin
            miscompares++;
            $display("FAIL selerr_hold: got err=%b occ=%h expected err=1 occ=%h",
                     sel_err, occ, occ_before);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_sel    = 4'b0010;
        for (int i = 0; i < 2; i++) begin
            in_data = 32'h200 + i;
            #1;
            tick();
        end
        in_valid = 1'b0;
        #1;
        vectors++;
        if (occ[1] !== 2'd2 || occ !== exp_occ()) begin
            miscompares++;
            $display("FAIL areset_loaded: got occ=%h expected %h", occ, exp_occ());
        end
        #1;
        rst_aL = 1'b0;
        model_clear();
        #1;
        vectors++;
        if (out_valid !== 4'b0000 || occ !== 8'h00) begin
            miscompares++;
            $display("FAIL areset_clear: got v=%b occ=%h expected v=0000 occ=00", out_valid, occ);
        end
        @(negedge clk);
        rst_aL = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (sel_err !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_sel_err: got %b expected 0", sel_err);
        end
        in_valid = 1'b1;
        in_sel   = 4'b0010;
        in_data  = 32'h77;
        #1;
        tick();
        in_valid = 1'b0;
        #1;
        vectors++;
        if (out_valid[1] !== 1'b1 || out_data[1] !== 32'h77 || occ[1] !== 2'd1) begin
            miscompares++;
            $display("FAIL areset_repush: got v=%b d=%h occ=%0d expected v=1 d=77 occ=1",
                     out_valid[1], out_data[1], occ[1]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = 4'($urandom);
            if ($urandom_range(0, 19) == 0) in_sel = 4'($urandom);
            else in_sel = 4'b0001 << $urandom_range(0, N_OUTS - 1);
            #1;
            vectors++;
            if (in_ready !== exp_ready()) begin
                miscompares++;
                $display("FAIL rand_ready cyc %0d: got %b expected %b", i, in_ready, exp_ready());
            end
            vectors++;
            if (out_valid !== exp_valid() || occ !== exp_occ()) begin
                miscompares++;
                $display("FAIL rand_state cyc %0d: got v=%b occ=%h expected v=%b occ=%h",
                         i, out_valid, occ, exp_valid(), exp_occ());
            end
            vectors++;
            if (sel_err !== sel_err_m) begin
                miscompares++;
                $display("FAIL rand_sel_err cyc %0d: got %b expected %b", i, sel_err, sel_err_m);
            end
            for (int k = 0; k < N_OUTS; k++) begin
                if (mq[k].size() != 0) begin
                    vectors++;
                    if (out_data[k] !== mq[k][0]) begin
                        miscompares++;
                        $display("FAIL rand_data cyc %0d ch %0d: got %h expected %h",
                                 i, k, out_data[k], mq[k][0]);
                    end
                end
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill_order();
        test_no_hol();
        test_stream();
        test_sel_err();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
